// File: rtl/bcd_share_arb.sv
// bcd_share_arb: round-robin arbiter that shares one binary-to-ASCII
// converter between N_REQ requesters. Each job is granted, checked for
// range (operands above 9999 are rejected without touching the converter),
// run on the converter and answered with a one-cycle ack pulse.
//
// Optional feature: define BCD_ARB_TIMEOUT_EN to add a per-job watchdog
// that aborts a conversion after TIMEOUT_CYC cycles in WAIT and answers
// with err_o = 1 and ascii_o = "????".
module bcd_share_arb #(
    parameter int unsigned N_REQ       = 4,
    parameter int unsigned BIN_W       = 14,
    parameter int unsigned TIMEOUT_CYC = 64
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [N_REQ-1:0]        req_i,
    input  logic [N_REQ*BIN_W-1:0]  bin_i,
    output logic [N_REQ-1:0]        ack_o,
    output logic                    err_o,
    output logic [31:0]             ascii_o,
    output logic                    conv_go,
    output logic [BIN_W-1:0]        conv_bin,
    input  logic                    conv_ready,
    input  logic [31:0]             conv_ascii
);

    localparam int unsigned      IDX_W     = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam logic [IDX_W-1:0] PTR_RST   = IDX_W'(N_REQ - 1);
    localparam logic [31:0]      ASCII_REJ = 32'h2D2D2D2D;
    localparam logic [31:0]      MAX_BCD   = 32'd9999;

    typedef enum logic [2:0] {
        IDLE,
        GRANT,
        WAIT,
        DROP,
        RESP
    } state_t;

    state_t            state;
    logic [IDX_W-1:0]  rr_ptr;
    logic [IDX_W-1:0]  win_idx;
    logic [IDX_W-1:0]  pick_idx;
    logic [IDX_W-1:0]  cand;
    logic              pick_vld;
    logic [N_REQ-1:0]  req_elig;
    logic              armed;
    logic              cap_err;
    logic [31:0]       cap_ascii;
    logic [BIN_W-1:0]  win_bin;
    logic              win_bad;

`ifdef BCD_ARB_TIMEOUT_EN
    localparam int unsigned  WD_W      = $clog2(TIMEOUT_CYC + 1);
    localparam logic [31:0]  ASCII_TMO = 32'h3F3F3F3F;
    logic [WD_W-1:0]         wdog;
    logic                    wd_hit;

    // Watchdog fires on the last permitted WAIT cycle
    assign wd_hit = (wdog == WD_W'(TIMEOUT_CYC - 1));
`endif

    // A requester whose ack is pulsing this cycle is still holding req high;
    // it must not be granted a second time.
    assign req_elig = req_i & ~ack_o;

    // Operand of the latched winner and its range check
    assign win_bin = bin_i[32'(win_idx) * BIN_W +: BIN_W];
    assign win_bad = (32'(win_bin) > MAX_BCD);

    // Round-robin search starting one past the last served requester
    always_comb begin
        pick_vld = 1'b0;
        pick_idx = '0;
        cand     = '0;
        for (int unsigned i = 1; i <= N_REQ; i++) begin
            cand = IDX_W'((32'(rr_ptr) + i) % N_REQ);
            if (!pick_vld && req_elig[cand]) begin
                pick_vld = 1'b1;
                pick_idx = cand;
            end
        end
    end

    // Job sequencer: grant, convert, drop the converter enable, respond
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            rr_ptr    <= PTR_RST;
            win_idx   <= '0;
            ack_o     <= '0;
            err_o     <= 1'b0;
            ascii_o   <= '0;
            conv_go   <= 1'b0;
            conv_bin  <= '0;
            armed     <= 1'b0;
            cap_err   <= 1'b0;
            cap_ascii <= '0;
`ifdef BCD_ARB_TIMEOUT_EN
            wdog      <= '0;
`endif
        end else begin
            ack_o   <= '0;
            err_o   <= 1'b0;
            ascii_o <= '0;
            case (state)
                IDLE: begin
                    if (pick_vld) begin
                        win_idx <= pick_idx;
                        state   <= GRANT;
                    end
                end
                GRANT: begin
                    if (win_bad) begin
                        cap_err   <= 1'b1;
                        cap_ascii <= ASCII_REJ;
                        state     <= RESP;
                    end else begin
                        cap_err   <= 1'b0;
                        cap_ascii <= '0;
                        conv_bin  <= win_bin;
                        conv_go   <= 1'b1;
                        armed     <= 1'b0;
`ifdef BCD_ARB_TIMEOUT_EN
                        wdog      <= '0;
`endif
                        state     <= WAIT;
                    end
                end
                WAIT: begin
                    // conv_ready is only trusted after it has been seen low,
                    // so a flag left over from the previous job is ignored.
`ifdef BCD_ARB_TIMEOUT_EN
                    wdog <= wdog + 1'b1;
                    if (wd_hit) begin
                        cap_err   <= 1'b1;
                        cap_ascii <= ASCII_TMO;
                        conv_go   <= 1'b0;
                        state     <= DROP;
                    end else
`endif
                    if (!conv_ready) begin
                        armed <= 1'b1;
                    end else if (armed) begin
                        cap_ascii <= conv_ascii;
                        conv_go   <= 1'b0;
                        state     <= DROP;
                    end
                end
                DROP: begin
                    state <= RESP;
                end
                RESP: begin
                    ack_o[win_idx] <= 1'b1;
                    err_o          <= cap_err;
                    ascii_o        <= cap_ascii;
                    rr_ptr         <= win_idx;
                    armed          <= 1'b0;
                    state          <= IDLE;
                end
                default: begin
                    conv_go <= 1'b0;
                    state   <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bcd_share_arb.sv
// Directed bench for bcd_share_arb with a behavioural converter model.
// Define BCD_ARB_TIMEOUT_EN when compiling to also exercise the watchdog.
module tb_bcd_share_arb;

    localparam int unsigned N = 4;
    localparam int unsigned W = 14;

    logic           clk = 1'b0;
    logic           rst;
    logic [N-1:0]   req_i;
    logic [N*W-1:0] bin_i;
    logic [N-1:0]   ack_o;
    logic           err_o;
    logic [31:0]    ascii_o;
    logic           conv_go;
    logic [W-1:0]   conv_bin;
    logic           conv_ready = 1'b0;
    logic [31:0]    conv_ascii = '0;

    int checks   = 0;
    int failures = 0;

    // converter model controls
    int stale_hold = 1;   // go cycles before a sticky ready flag clears
    int lat        = 3;   // further go cycles until the result appears
    bit never      = 1'b0;
    int cnt        = 0;

    int go_cnt = 0;
    int viol   = 0;

    always #5 clk = ~clk;

    bcd_share_arb #(
        .N_REQ       (N),
        .BIN_W       (W),
        .TIMEOUT_CYC (64)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .req_i      (req_i),
        .bin_i      (bin_i),
        .ack_o      (ack_o),
        .err_o      (err_o),
        .ascii_o    (ascii_o),
        .conv_go    (conv_go),
        .conv_bin   (conv_bin),
        .conv_ready (conv_ready),
        .conv_ascii (conv_ascii)
    );

    function automatic logic [31:0] to_ascii(input logic [W-1:0] v);
        int unsigned x;
        x = 32'(v);
        return {8'h30 + 8'(x / 1000), 8'h30 + 8'((x / 100) % 10),
                8'h30 + 8'((x / 10) % 10), 8'h30 + 8'(x % 10)};
    endfunction

    // Converter: restarts when go rises, ready is sticky until restart
    always @(negedge clk) begin
        if (conv_go) begin
            cnt = cnt + 1;
            if (cnt == stale_hold) conv_ready = 1'b0;
            if (!never && cnt == stale_hold + lat) begin
                conv_ready = 1'b1;
                conv_ascii = to_ascii(conv_bin);
            end
        end else begin
            cnt = 0;
        end
    end

    // Output-protocol watch: one-hot ack, quiet data outside ack cycles
    always @(negedge clk) begin
        if (conv_go) go_cnt = go_cnt + 1;
        if (rst === 1'b1 && ack_o == '0 && (err_o !== 1'b0 || ascii_o !== '0)) viol = viol + 1;
        if (!$onehot0(ack_o)) viol = viol + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic set_bin(input int k, input logic [W-1:0] v);
        bin_i[k*W +: W] = v;
    endtask

    task automatic wait_ack(output logic [N-1:0] a, output logic e,
                            output logic [31:0] s, output int cyc);
        bit got;
        got = 1'b0;
        a = '0; e = 1'b0; s = '0; cyc = 0;
        for (int i = 0; i < 300 && !got; i++) begin
            @(negedge clk);
            cyc++;
            if (ack_o != '0) begin
                a     = ack_o;
                e     = err_o;
                s     = ascii_o;
                req_i = req_i & ~ack_o;
                got   = 1'b1;
            end
        end
    endtask

    logic [N-1:0] a;
    logic         e;
    logic [31:0]  s;
    int           cyc;
    int           go_before;
    logic [31:0]  exp33 [4];

    initial begin
        exp33[0] = 32'h30303030;
        exp33[1] = 32'h30303039;
        exp33[2] = 32'h34303935;
        exp33[3] = 32'h39393939;

        rst   = 1'b1;
        req_i = '0;
        bin_i = '0;
        #1 rst = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_ack",  32'(ack_o),    32'h0);
        chk("rst_err",  32'(err_o),    32'h0);
        chk("rst_asc",  ascii_o,       32'h0);
        chk("rst_go",   32'(conv_go),  32'h0);
        chk("rst_bin",  32'(conv_bin), 32'h0);
        rst = 1'b1;
        @(negedge clk);

        // four simultaneous requests, served 0,1,2,3
        set_bin(0, 14'd0);
        set_bin(1, 14'd9);
        set_bin(2, 14'd4095);
        set_bin(3, 14'd9999);
        req_i = 4'b1111;
        for (int j = 0; j < 4; j++) begin
            wait_ack(a, e, s, cyc);
            chk("rr_ack", 32'(a), 32'(4'b0001 << j));
            chk("rr_asc", s, exp33[j]);
            chk("rr_err", 32'(e), 32'h0);
        end

        // single request with latency check
        @(negedge clk);
        set_bin(0, 14'd1234);
        req_i = 4'b0001;
        wait_ack(a, e, s, cyc);
        chk("one_ack", 32'(a), 32'h1);
        chk("one_asc", s, 32'h31323334);
        chk("one_err", 32'(e), 32'h0);
        chk("one_lat", 32'(cyc), 32'd8);

        // out-of-range operand on requester 2
        @(negedge clk);
        go_before = go_cnt;
        set_bin(2, 14'd12000);
        req_i = 4'b0100;
        wait_ack(a, e, s, cyc);
        chk("rej_ack", 32'(a), 32'h4);
        chk("rej_err", 32'(e), 32'h1);
        chk("rej_asc", s, 32'h2D2D2D2D);
        chk("rej_lat", 32'(cyc), 32'd3);
        chk("rej_go",  32'(go_cnt - go_before), 32'd0);

        // reset in mid-WAIT: requester 3 is granted, then pointer restarts at 0
        @(negedge clk);
        set_bin(0, 14'd7);
        set_bin(3, 14'd5000);
        req_i = 4'b1001;
        repeat (4) @(negedge clk);
        chk("mid_go", 32'(conv_go), 32'h1);
        rst = 1'b0;
        #1;
        chk("arst_go",  32'(conv_go), 32'h0);
        chk("arst_ack", 32'(ack_o),   32'h0);
        repeat (2) @(negedge clk);
        chk("arst_ack2", 32'(ack_o), 32'h0);
        rst = 1'b1;
        wait_ack(a, e, s, cyc);
        chk("post_ack0", 32'(a), 32'h1);
        chk("post_asc0", s, 32'h30303037);
        wait_ack(a, e, s, cyc);
        chk("post_ack3", 32'(a), 32'h8);
        chk("post_asc3", s, 32'h35303030);

        // stale ready from previous job must be ignored
        @(negedge clk);
        stale_hold = 4;
        lat        = 2;
        set_bin(3, 14'd42);
        req_i = 4'b1000;
        wait_ack(a, e, s, cyc);
        chk("stale_ack", 32'(a), 32'h8);
        chk("stale_asc", s, 32'h30303432);
        chk("stale_lat", 32'(cyc), 32'd10);
        stale_hold = 1;
        lat        = 3;

`ifdef BCD_ARB_TIMEOUT_EN
        // converter never completes: watchdog aborts, requester 1 next
        @(negedge clk);
        never = 1'b1;
        set_bin(0, 14'd1);
        set_bin(1, 14'd2);
        req_i = 4'b0011;
        wait_ack(a, e, s, cyc);
        never = 1'b0;
        chk("tmo_ack", 32'(a), 32'h1);
        chk("tmo_err", 32'(e), 32'h1);
        chk("tmo_asc", s, 32'h3F3F3F3F);
        chk("tmo_lat", 32'(cyc), 32'd68);
        wait_ack(a, e, s, cyc);
        chk("tmo_next_ack", 32'(a), 32'h2);
        chk("tmo_next_asc", s, 32'h30303032);
        chk("tmo_next_err", 32'(e), 32'h0);
`endif

        repeat (3) @(negedge clk);
        chk("protocol", 32'(viol), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
